// File: rtl/tone_decoder_if.sv
// Interface bundling the tone input and all decoded outputs of tone_decoder.
// slave  : the decoder side (drives the measurement/decode results).
// master : the consumer side (supplies tone_in, observes the results).
interface tone_decoder_if #(
  parameter int CNT_W = 20
);
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic [5:0]       fullnote;
  logic [2:0]       octave;
  logic [3:0]       note;
  logic             note_valid;
  logic             note_strobe;
  logic [4:0]       hex_hi;
  logic [4:0]       hex_lo;

  modport master (
    output tone_in,
    input  period, fullnote, octave, note, note_valid, note_strobe, hex_hi, hex_lo
  );

  modport slave (
    input  tone_in,
    output period, fullnote, octave, note, note_valid, note_strobe, hex_hi, hex_lo
  );
endinterface

// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a square wave in clk0 cycles and
// decodes it into the buzzer fullnote code (octave*12 + note).
// Optional macro HEXOUT_EN: when defined, hex_hi/hex_lo carry the note letter
// and sharp marker as hexdigit codes; otherwise both are tied to blank (31).
module tone_decoder #(
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 600000,
  parameter int STABLE_CNT = 3
) (
  input  logic         clk0,
  input  logic         rst,
  tone_decoder_if.slave bus
);

  localparam int W    = CNT_W + 4;
  localparam int SC_W = $clog2(STABLE_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT - 1);
  localparam logic [W-1:0]     N_MIN    = W'(263);
  localparam logic [W-1:0]     N_MAX    = W'(527);
  localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(1);
  localparam logic [SC_W-1:0]  SC_FULL  = SC_W'(STABLE_CNT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MEAS = 1'b1} state_t;

  // Note index within the octave: first threshold that N reaches, else G#.
  function automatic logic [3:0] classify_note(input logic [W-1:0] n);
    logic [3:0] r;
    if      (n >= W'(498)) r = 4'd0;
    else if (n >= W'(470)) r = 4'd1;
    else if (n >= W'(444)) r = 4'd2;
    else if (n >= W'(419)) r = 4'd3;
    else if (n >= W'(395)) r = 4'd4;
    else if (n >= W'(373)) r = 4'd5;
    else if (n >= W'(352)) r = 4'd6;
    else if (n >= W'(333)) r = 4'd7;
    else if (n >= W'(314)) r = 4'd8;
    else if (n >= W'(296)) r = 4'd9;
    else if (n >= W'(279)) r = 4'd10;
    else                   r = 4'd11;
    return r;
  endfunction

  logic             sync1_r, sync2_r, prev_r;
  logic             edge_s;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             capture_s, timeout_s;

  logic             busy_r, found_r, oor_r;
  logic [2:0]       step_r, k_r;
  logic [W-1:0]     n_r, shifted_s, n_s;

  logic             cand_valid_r;
  logic [2:0]       cand_oct_r;
  logic [3:0]       cand_note_r;
  logic [5:0]       cand_full_r;
  logic [3:0]       cls_note_s;
  logic [5:0]       cls_full_s;

  logic             prev_valid_r;
  logic [5:0]       prev_full_r;
  logic [SC_W-1:0]  scnt_r, scnt_next_s;
  logic             match_s, differ_s, commit_stage_s, commit_s;

  logic [CNT_W-1:0] period_r;
  logic [5:0]       fullnote_r;
  logic [2:0]       octave_r;
  logic [3:0]       note_r;
  logic             note_valid_r, note_strobe_r;

  // Two-flop synchronizer for the asynchronous tone plus a delayed copy for edge detection.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= bus.tone_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign edge_s = sync2_r & ~prev_r;

  // Measurement FSM state and period counter registers.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state: first edge arms the counter, later edges capture unless decode is busy.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          state_s = ST_MEAS;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r;
        end
      end
      ST_MEAS: begin
        if (edge_s) begin
          cnt_s     = CNT_ZERO;
          capture_s = ~busy_r;
        end else if (cnt_r == CNT_TO) begin
          timeout_s = 1'b1;
          state_s   = ST_IDLE;
          cnt_s     = CNT_ZERO;
        end else begin
          cnt_s     = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Octave search operand: period scaled by 2^step, wide enough that no bit is lost.
  assign shifted_s = {4'b0000, period_r} << step_r;
  assign n_s       = shifted_s >> 4'd9;

  // Candidate code built from the latched octave search result.
  always_comb begin
    cls_note_s = classify_note(n_r);
    cls_full_s = ({3'b000, k_r} * 6'd12) + {2'b00, cls_note_s};
  end

  // Stability filter: count repeats of the same candidate, commit only on a real change.
  always_comb begin
    match_s        = ({cand_valid_r, cand_full_r} == {prev_valid_r, prev_full_r});
    differ_s       = ({cand_valid_r, cand_full_r} != {note_valid_r, fullnote_r});
    commit_stage_s = busy_r & (step_r == 3'd6) & ~timeout_s;
    if (match_s) begin
      if (scnt_r == SC_FULL) begin
        scnt_next_s = scnt_r;
      end else begin
        scnt_next_s = scnt_r + SC_ONE;
      end
    end else begin
      scnt_next_s = SC_ONE;
    end
    commit_s = commit_stage_s & (scnt_next_s == SC_FULL) & differ_s;
  end

  // Capture, fixed-latency decode pipeline, stability state and registered outputs.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      period_r      <= CNT_ZERO;
      fullnote_r    <= 6'd0;
      octave_r      <= 3'd0;
      note_r        <= 4'd0;
      note_valid_r  <= 1'b0;
      note_strobe_r <= 1'b0;
      busy_r        <= 1'b0;
      step_r        <= 3'd0;
      found_r       <= 1'b0;
      oor_r         <= 1'b0;
      k_r           <= 3'd0;
      n_r           <= {W{1'b0}};
      cand_valid_r  <= 1'b0;
      cand_oct_r    <= 3'd0;
      cand_note_r   <= 4'd0;
      cand_full_r   <= 6'd0;
      prev_valid_r  <= 1'b0;
      prev_full_r   <= 6'd0;
      scnt_r        <= {SC_W{1'b0}};
    end else begin
      note_strobe_r <= 1'b0;
      if (timeout_s) begin
        period_r      <= CNT_ZERO;
        fullnote_r    <= 6'd0;
        octave_r      <= 3'd0;
        note_r        <= 4'd0;
        note_valid_r  <= 1'b0;
        note_strobe_r <= note_valid_r;
        busy_r        <= 1'b0;
        step_r        <= 3'd0;
        found_r       <= 1'b0;
        oor_r         <= 1'b0;
        prev_valid_r  <= 1'b0;
        prev_full_r   <= 6'd0;
        scnt_r        <= {SC_W{1'b0}};
      end else if (capture_s) begin
        period_r <= (cnt_r == CNT_MAX) ? CNT_MAX : (cnt_r + CNT_ONE);
        busy_r   <= 1'b1;
        step_r   <= 3'd0;
        found_r  <= 1'b0;
        oor_r    <= 1'b0;
      end else if (busy_r) begin
        case (step_r)
          3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
            if (!found_r && !oor_r) begin
              if ((step_r == 3'd0) && (n_s > N_MAX)) begin
                oor_r <= 1'b1;
              end else if (n_s >= N_MIN) begin
                found_r <= 1'b1;
                k_r     <= step_r;
                n_r     <= n_s;
              end else begin
                found_r <= 1'b0;
              end
            end else begin
              found_r <= found_r;
            end
            step_r <= step_r + 3'd1;
          end
          3'd5: begin
            // A found octave excludes the too-low flag, so found alone means in range.
            cand_valid_r <= found_r;
            cand_oct_r   <= found_r ? k_r : 3'd0;
            cand_note_r  <= found_r ? cls_note_s : 4'd0;
            cand_full_r  <= found_r ? cls_full_s : 6'd0;
            step_r       <= 3'd6;
          end
          3'd6: begin
            prev_valid_r <= cand_valid_r;
            prev_full_r  <= cand_full_r;
            scnt_r       <= scnt_next_s;
            if (commit_s) begin
              note_valid_r  <= cand_valid_r;
              fullnote_r    <= cand_full_r;
              octave_r      <= cand_oct_r;
              note_r        <= cand_note_r;
              note_strobe_r <= 1'b1;
            end else begin
              note_strobe_r <= 1'b0;
            end
            busy_r <= 1'b0;
            step_r <= 3'd0;
          end
          default: begin
            busy_r <= 1'b0;
            step_r <= 3'd0;
          end
        endcase
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.period      = period_r;
  assign bus.fullnote    = fullnote_r;
  assign bus.octave      = octave_r;
  assign bus.note        = note_r;
  assign bus.note_valid  = note_valid_r;
  assign bus.note_strobe = note_strobe_r;

`ifdef HEXOUT_EN
  // Note letter A..G as hexdigit code (sharps share the letter below them).
  function automatic logic [4:0] hex_letter(input logic [3:0] n);
    logic [4:0] r;
    case (n)
      4'd0, 4'd1:   r = 5'ha;
      4'd2:         r = 5'hb;
      4'd3, 4'd4:   r = 5'hc;
      4'd5, 4'd6:   r = 5'hd;
      4'd7:         r = 5'he;
      4'd8, 4'd9:   r = 5'hf;
      4'd10, 4'd11: r = 5'd20;
      default:      r = 5'd31;
    endcase
    return r;
  endfunction

  // Sharp marker for the black-key notes, blank otherwise.
  function automatic logic [4:0] hex_sharp(input logic [3:0] n);
    logic [4:0] r;
    case (n)
      4'd1, 4'd4, 4'd6, 4'd9, 4'd11: r = 5'd24;
      default:                       r = 5'd31;
    endcase
    return r;
  endfunction

  logic [4:0] hex_hi_r, hex_lo_r;

  // Display codes follow the committed note; blank whenever no valid note is shown.
  always_ff @(posedge clk0 or negedge rst) begin
    if (!rst) begin
      hex_hi_r <= 5'd31;
      hex_lo_r <= 5'd31;
    end else if (timeout_s) begin
      hex_hi_r <= 5'd31;
      hex_lo_r <= 5'd31;
    end else if (commit_s) begin
      hex_hi_r <= cand_valid_r ? hex_letter(cand_note_r) : 5'd31;
      hex_lo_r <= cand_valid_r ? hex_sharp(cand_note_r)  : 5'd31;
    end else begin
      hex_hi_r <= hex_hi_r;
      hex_lo_r <= hex_lo_r;
    end
  end

  assign bus.hex_hi = hex_hi_r;
  assign bus.hex_lo = hex_lo_r;
`else
  assign bus.hex_hi = 5'd31;
  assign bus.hex_lo = 5'd31;
`endif

endmodule
